frame_writer: RTL and testbench
===============================

# frame_writer

Writes an incoming RGB byte stream into the image RAM that the pixel fetch path reads. It accepts bytes over a valid/ready handshake and tracks raster position (y, x, component). Each accepted byte becomes one write on the RAM's dedicated write port, using the same address map as the read side: bit 18 = 0, [17:10] = y, [9:2] = x, [1:0] = component. It sits between the host link receiver and the image RAM.

## Interface
Parameters:
- WRITE_PAD, default 0: when 1, writes 8'h00 to component slot 3 after every B byte. This costs one stall cycle per pixel.

Ports:
- clk  in  1  system clock (30 MHz); one clock, all logic on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_sof  in  1  qualifies in_data as the first byte of a frame (R of y=0, x=0); meaningful only while in_valid=1
- in_ready  out  1  writer accepts a byte this cycle; registered
- ram_waddr  out  19  RAM write address
- ram_wdata  out  8  RAM write data
- ram_we  out  1  write strobe, one byte per cycle
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last write of a frame
- frame_error  out  1  one-cycle pulse on protocol error

## Operation
- Accept: a byte is accepted when in_valid & in_ready.
- Byte order: raster order, y-major, then x, then R, G, B.
  - Frame length is 196608 bytes (256×256×3).
- Counters:
  - comp counts 0..2, then wraps.
  - x (8 bit) increments on comp wrap.
  - y (8 bit) increments on x wrap from 255 to 0.
- States:
  - IDLE: in_ready=1, busy=0.
    - Accepted byte with in_sof=1: write it as y=0, x=0, comp=0 (R), then go to LOAD.
    - Accepted byte with in_sof=0: discard it (no write) and pulse frame_error.
  - LOAD: busy=1.
    - Each accepted byte is written at the current counters, then the counters advance.
    - If WRITE_PAD=1 and the byte is B (comp=2), go to PAD.
    - When the accepted byte is y=255, x=255, comp=2: with WRITE_PAD=0, go to IDLE and pulse frame_done; with WRITE_PAD=1, go to PAD.
  - PAD: in_ready=0. Issue the comp=3 write with data 8'h00 at the same (y, x) as the B byte just written.
    - Return to LOAD, or to IDLE with a frame_done pulse if that pixel was y=255, x=255.
- Mid-frame in_sof=1 (accepted in LOAD):
  - Pulse frame_error.
  - Reset the counters; this byte is written as R of (0, 0) of a new frame.
  - Stay in LOAD.
- Arithmetic: all counters are unsigned and wrap modulo their width. No saturation.
- Reset mid-frame:
  - All state clears immediately and any partially written frame is abandoned.
  - After release the writer waits in IDLE for in_sof.

## Timing
- Reset values: in_ready=1, ram_we=0, ram_waddr=0, ram_wdata=0, busy=0, frame_done=0, frame_error=0. State is IDLE with counters at 0.
- Write latency: a byte accepted at cycle N appears on ram_waddr/ram_wdata with ram_we=1 at N+1. The outputs are registered.
- ram_we is 0 on every cycle without a pending write. ram_waddr/ram_wdata hold their last value.
- PAD (WRITE_PAD=1), with B accepted at N:
  - N+1: B write; in_ready=0.
  - N+2: pad write; in_ready=1.
  - The next byte is accepted at N+2 at the earliest and written at N+3.
- frame_done: asserted in the cycle after the final write (final B write, or final pad write), for exactly one cycle. busy falls in the same cycle.
- frame_error: asserted in the cycle after the offending accept, for one cycle.
- in_valid=0 gaps of any length are allowed and do not change the counters.
- The RAM write port is independent of the read port. Read/write collisions on the same address are resolved by the RAM; this block does not arbitrate them.

## Structure
- Shared package roseace_pkg:
  - IMG_DIM = 256.
  - Component enum: COMP_R=0, COMP_G=1, COMP_B=2, COMP_PAD=3.
  - Function pixel_ram_addr(y, x, comp) returning the 19-bit address. The read-side address path also uses this function so both sides share one map.
  - The state enum (IDLE, LOAD, PAD) is local to this module.
- Single module, no sub-module. The counter chain and FSM are small enough to stay flat.

## Test plan
- Full frame, WRITE_PAD=0, in_valid held 1, bytes = low 8 bits of the byte index:
  - Expect 196608 writes.
  - Write k has ram_waddr = {0, y, x, comp} decoded from k; last address 19'h3FFFE.
  - frame_done is one pulse, one cycle after the last write; no frame_error.
- WRITE_PAD=1, one pixel R=8'h11, G=8'h22, B=8'h33 at (0,0):
  - Writes to addresses 0..3 with data 11, 22, 33, 00.
  - in_ready=0 exactly in the B-write cycle.
- Byte with in_sof=0 in IDLE: no ram_we, one frame_error pulse, busy stays 0.
- in_sof reasserted after 1000 bytes:
  - One frame_error pulse.
  - That byte is written to address 0; the following byte to address 1.
- Random in_valid gaps (~30% idle) over a full frame: the address/data sequence is identical to the first scenario.
- rst_n pulled low mid-frame at byte 500, asynchronous to clk:
  - All outputs reach their reset values without waiting for a clock edge.
  - After release, no writes occur until in_sof; the new frame starts at address 0.

Source files
------------

// File: rtl/roseace_pkg.sv
// Shared definitions for the image RAM: dimensions, component slots and the
// pixel address map used by both the write path and the pixel fetch path.
package roseace_pkg;

  localparam int IMG_DIM = 256;

  typedef enum logic [1:0] {
    COMP_R   = 2'd0,
    COMP_G   = 2'd1,
    COMP_B   = 2'd2,
    COMP_PAD = 2'd3
  } comp_e;

  // Bit 18 is reserved (always 0); y and x select the pixel, comp the byte slot.
  function automatic logic [18:0] pixel_ram_addr(input logic [7:0] y,
                                                 input logic [7:0] x,
                                                 input logic [1:0] comp);
    return {1'b0, y, x, comp};
  endfunction

endpackage

// File: rtl/frame_writer.sv
// Writes a raster-ordered RGB byte stream into the image RAM, tracking
// (y, x, component) and optionally filling the unused fourth byte of each pixel.
module frame_writer
  import roseace_pkg::*;
#(
  parameter bit WRITE_PAD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sof,
  output logic        in_ready,
  output logic [18:0] ram_waddr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;

  localparam logic [7:0] LAST_POS = 8'(IMG_DIM - 1);

  logic [1:0]  state_reg, state_next;
  logic [1:0]  comp_reg, comp_next;
  logic [7:0]  x_reg, x_next;
  logic [7:0]  y_reg, y_next;
  logic        in_ready_reg;
  logic [18:0] ram_waddr_reg, ram_waddr_next;
  logic [7:0]  ram_wdata_reg, ram_wdata_next;
  logic        ram_we_reg, ram_we_next;
  logic        busy_reg;
  logic        last_reg, last_next;
  logic        frame_done_reg;
  logic        frame_error_reg, frame_error_next;

  logic accept;
  logic pixel_last;

  assign accept     = in_valid & in_ready_reg;
  assign pixel_last = (y_reg == LAST_POS) && (x_reg == LAST_POS);

  always_comb begin
    state_next       = state_reg;
    comp_next        = comp_reg;
    x_next           = x_reg;
    y_next           = y_reg;
    ram_we_next      = 1'b0;
    ram_waddr_next   = ram_waddr_reg;
    ram_wdata_next   = ram_wdata_reg;
    frame_error_next = 1'b0;
    last_next        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (in_sof) begin
            ram_we_next    = 1'b1;
            ram_waddr_next = pixel_ram_addr(8'd0, 8'd0, COMP_R);
            ram_wdata_next = in_data;
            comp_next      = COMP_G;
            x_next         = 8'd0;
            y_next         = 8'd0;
            state_next     = ST_LOAD;
          end else begin
            frame_error_next = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (accept) begin
          ram_we_next    = 1'b1;
          ram_wdata_next = in_data;
          if (in_sof) begin
            // Restart: this byte becomes R of pixel (0, 0) of a fresh frame.
            frame_error_next = 1'b1;
            ram_waddr_next   = pixel_ram_addr(8'd0, 8'd0, COMP_R);
            comp_next        = COMP_G;
            x_next           = 8'd0;
            y_next           = 8'd0;
          end else begin
            ram_waddr_next = pixel_ram_addr(y_reg, x_reg, comp_reg);
            if (comp_reg == COMP_B) begin
              if (WRITE_PAD) begin
                // Hold (y, x) so the pad cycle addresses the same pixel.
                comp_next  = COMP_PAD;
                state_next = ST_PAD;
              end else begin
                comp_next = COMP_R;
                x_next    = x_reg + 8'd1;
                if (x_reg == LAST_POS) begin
                  y_next = y_reg + 8'd1;
                end
                if (pixel_last) begin
                  state_next = ST_IDLE;
                  last_next  = 1'b1;
                end
              end
            end else begin
              comp_next = comp_reg + 2'd1;
            end
          end
        end
      end

      ST_PAD: begin
        ram_we_next    = 1'b1;
        ram_waddr_next = pixel_ram_addr(y_reg, x_reg, COMP_PAD);
        ram_wdata_next = 8'h00;
        comp_next      = COMP_R;
        x_next         = x_reg + 8'd1;
        if (x_reg == LAST_POS) begin
          y_next = y_reg + 8'd1;
        end
        if (pixel_last) begin
          state_next = ST_IDLE;
          last_next  = 1'b1;
        end else begin
          state_next = ST_LOAD;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      comp_reg        <= 2'd0;
      x_reg           <= 8'd0;
      y_reg           <= 8'd0;
      in_ready_reg    <= 1'b1;
      ram_waddr_reg   <= 19'd0;
      ram_wdata_reg   <= 8'd0;
      ram_we_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      last_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      comp_reg        <= comp_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      in_ready_reg    <= (state_next != ST_PAD);
      ram_waddr_reg   <= ram_waddr_next;
      ram_wdata_reg   <= ram_wdata_next;
      ram_we_reg      <= ram_we_next;
      // busy covers the final write cycle and drops together with frame_done.
      busy_reg        <= (state_next != ST_IDLE) | last_next;
      last_reg        <= last_next;
      frame_done_reg  <= last_reg;
      frame_error_reg <= frame_error_next;
    end
  end

  assign in_ready    = in_ready_reg;
  assign ram_waddr   = ram_waddr_reg;
  assign ram_wdata   = ram_wdata_reg;
  assign ram_we      = ram_we_reg;
  assign busy        = busy_reg;
  assign frame_done  = frame_done_reg;
  assign frame_error = frame_error_reg;

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: one instance without padding, one with.
// Expected writes come from byte-index arithmetic over the frame.
module tb_frame_writer;
  import roseace_pkg::*;

  localparam int FRAME_BYTES = 196608;

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  data;
    bit          last;
  } exp_t;

  typedef struct {
    bit          valid;
    bit          sof;
    logic [7:0]  data;
    bit          we;
    logic [18:0] addr;
    logic [7:0]  wdata;
    bit          ready;
    bit          busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  data0, data1;
  logic        valid0, valid1, sof0, sof1;
  logic        ready0, ready1;
  logic [18:0] waddr0, waddr1;
  logic [7:0]  wdata0, wdata1;
  logic        we0, we1, busy0, busy1, done0, done1, err0, err1;

  frame_writer #(.WRITE_PAD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(data0), .in_valid(valid0), .in_sof(sof0),
    .in_ready(ready0), .ram_waddr(waddr0), .ram_wdata(wdata0), .ram_we(we0),
    .busy(busy0), .frame_done(done0), .frame_error(err0)
  );

  frame_writer #(.WRITE_PAD(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(data1), .in_valid(valid1), .in_sof(sof1),
    .in_ready(ready1), .ram_waddr(waddr1), .ram_wdata(wdata1), .ram_we(we1),
    .busy(busy1), .frame_done(done1), .frame_error(err1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int k [2];
  bit in_frame [2];
  int err_exp [2];
  int done_exp [2];
  int err_seen [2];
  int done_seen [2];
  int final_cyc [2];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t mon_e0, mon_e1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [18:0] byte_addr(input int idx);
    return 19'((idx / 3) * 4 + (idx % 3));
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Reference: a frame is FRAME_BYTES bytes; byte idx is pixel idx/3, slot idx%3.
  task automatic model_accept(input int d, input logic [7:0] b, input bit s);
    exp_t e;
    if (s) begin
      if (in_frame[d]) err_exp[d]++;
      k[d] = 0;
      in_frame[d] = 1'b1;
    end else if (!in_frame[d]) begin
      err_exp[d]++;
      return;
    end
    e.addr = byte_addr(k[d]);
    e.data = b;
    e.last = (d == 0) && (k[d] == FRAME_BYTES - 1);
    push(d, e);
    if (d == 1 && (k[d] % 3) == 2) begin
      e.addr = 19'((k[d] / 3) * 4 + 3);
      e.data = 8'h00;
      e.last = (k[d] == FRAME_BYTES - 1);
      push(d, e);
    end
    k[d]++;
    if (k[d] == FRAME_BYTES) begin
      in_frame[d] = 1'b0;
      done_exp[d]++;
    end
  endtask

  task automatic drive(input int d, input bit v, input bit s, input logic [7:0] b);
    if (d == 0) begin
      valid0 = v; sof0 = s; data0 = b;
    end else begin
      valid1 = v; sof1 = s; data1 = b;
    end
  endtask

  function automatic bit ready_of(input int d);
    return (d == 0) ? ready0 : ready1;
  endfunction

  task automatic send(input int d, input logic [7:0] b, input bit s);
    bit acc;
    int w;
    acc = 1'b0;
    w = 0;
    while (!acc && w < 8) begin
      drive(d, 1'b1, s, b);
      acc = ready_of(d);
      @(posedge clk); #1;
      if (acc) model_accept(d, b, s);
      w++;
    end
    drive(d, 1'b0, 1'b0, b);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL d%0d accept timeout: in_ready low for %0d cycles, required 1", d, w);
    end
  endtask

  // Idle cycles; in_sof toggles randomly to show it is ignored without in_valid.
  task automatic gap(input int d, input int n);
    repeat (n) begin
      drive(d, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      @(posedge clk); #1;
    end
    drive(d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_reset(input int d);
    if (d == 0) begin
      check("d0 rst in_ready", 32'(ready0), 32'd1);
      check("d0 rst ram_we", 32'(we0), 32'd0);
      check("d0 rst ram_waddr", 32'(waddr0), 32'd0);
      check("d0 rst ram_wdata", 32'(wdata0), 32'd0);
      check("d0 rst busy", 32'(busy0), 32'd0);
      check("d0 rst frame_done", 32'(done0), 32'd0);
      check("d0 rst frame_error", 32'(err0), 32'd0);
    end else begin
      check("d1 rst in_ready", 32'(ready1), 32'd1);
      check("d1 rst ram_we", 32'(we1), 32'd0);
      check("d1 rst ram_waddr", 32'(waddr1), 32'd0);
      check("d1 rst ram_wdata", 32'(wdata1), 32'd0);
      check("d1 rst busy", 32'(busy1), 32'd0);
    end
  endtask

  // Scoreboard: every ram_we must match the next expected write, in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we0) begin
        if (q0.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL d0 spurious write: addr %0h data %0h, required no write", waddr0, wdata0);
        end else begin
          mon_e0 = q0.pop_front();
          check("d0 waddr", 32'(waddr0), 32'(mon_e0.addr));
          check("d0 wdata", 32'(wdata0), 32'(mon_e0.data));
          if (mon_e0.last) final_cyc[0] = cyc;
        end
      end
      if (err0) err_seen[0]++;
      if (done0) begin
        done_seen[0]++;
        check("d0 done after last write", 32'(cyc), 32'(final_cyc[0] + 1));
        check("d0 busy low with done", 32'(busy0), 32'd0);
      end
      if (we1) begin
        if (q1.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL d1 spurious write: addr %0h data %0h, required no write", waddr1, wdata1);
        end else begin
          mon_e1 = q1.pop_front();
          check("d1 waddr", 32'(waddr1), 32'(mon_e1.addr));
          check("d1 wdata", 32'(wdata1), 32'(mon_e1.data));
          if (mon_e1.last) final_cyc[1] = cyc;
        end
      end
      if (err1) err_seen[1]++;
      if (done1) done_seen[1]++;
    end
  end

  initial begin
    vec_t tv [7];
    bit acc;

    for (int d = 0; d < 2; d++) begin
      k[d] = 0; in_frame[d] = 0; err_exp[d] = 0; done_exp[d] = 0;
      err_seen[d] = 0; done_seen[d] = 0; final_cyc[d] = -10;
    end
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);

    // One padded pixel then a paused stream; in_ready drops only in the B-write cycle.
    tv[0] = '{1'b1, 1'b1, 8'h11, 1'b1, 19'd0, 8'h11, 1'b1, 1'b1};
    tv[1] = '{1'b1, 1'b0, 8'h22, 1'b1, 19'd1, 8'h22, 1'b1, 1'b1};
    tv[2] = '{1'b1, 1'b0, 8'h33, 1'b1, 19'd2, 8'h33, 1'b0, 1'b1};
    tv[3] = '{1'b1, 1'b0, 8'h44, 1'b1, 19'd3, 8'h00, 1'b1, 1'b1};
    tv[4] = '{1'b1, 1'b0, 8'h44, 1'b1, 19'd4, 8'h44, 1'b1, 1'b1};
    tv[5] = '{1'b0, 1'b1, 8'h99, 1'b0, 19'd4, 8'h44, 1'b1, 1'b1};
    tv[6] = '{1'b1, 1'b0, 8'h55, 1'b1, 19'd5, 8'h55, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      drive(1, tv[i].valid, tv[i].sof, tv[i].data);
      acc = tv[i].valid & ready1;
      @(posedge clk); #1;
      if (acc) model_accept(1, tv[i].data, tv[i].sof);
      check($sformatf("tbl%0d ram_we", i), 32'(we1), 32'(tv[i].we));
      check($sformatf("tbl%0d ram_waddr", i), 32'(waddr1), 32'(tv[i].addr));
      check($sformatf("tbl%0d ram_wdata", i), 32'(wdata1), 32'(tv[i].wdata));
      check($sformatf("tbl%0d in_ready", i), 32'(ready1), 32'(tv[i].ready));
      check($sformatf("tbl%0d busy", i), 32'(busy1), 32'(tv[i].busy));
    end
    drive(1, 1'b0, 1'b0, 8'h00);

    // Padded stream with random gaps.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3) gap(1, $urandom_range(1, 3));
      send(1, 8'($urandom), 1'b0);
    end
    gap(1, 4);
    check("d1 writes drained", 32'(q1.size()), 32'd0);

    // Stray byte in IDLE: discarded with an error pulse.
    send(0, 8'hA5, 1'b0);
    check("idle stray frame_error", 32'(err0), 32'd1);
    check("idle stray ram_we", 32'(we0), 32'd0);
    check("idle stray busy", 32'(busy0), 32'd0);
    gap(0, 1);
    check("idle stray error one cycle", 32'(err0), 32'd0);

    // Full frame, continuous, byte value = low 8 bits of the byte index.
    for (int i = 0; i < FRAME_BYTES; i++) begin
      send(0, 8'(i), i == 0);
      if (i == FRAME_BYTES / 2) check("full frame busy mid", 32'(busy0), 32'd1);
    end
    check("full frame last addr", 32'(waddr0), 32'h3FFFE);
    gap(0, 3);
    check("full frame done pulses", 32'(done_seen[0]), 32'd1);
    check("full frame done model", 32'(done_seen[0]), 32'(done_exp[0]));
    check("full frame busy after", 32'(busy0), 32'd0);
    check("d0 writes drained", 32'(q0.size()), 32'd0);

    // Gapped stream, restarted by in_sof after 1000 bytes.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 9) < 3) gap(0, $urandom_range(1, 4));
      send(0, 8'($urandom), i == 0);
    end
    send(0, 8'hC3, 1'b1);
    check("restart frame_error", 32'(err0), 32'd1);
    check("restart waddr", 32'(waddr0), 32'd0);
    check("restart wdata", 32'(wdata0), 32'hC3);
    send(0, 8'h3C, 1'b0);
    check("restart next error clear", 32'(err0), 32'd0);
    check("restart next waddr", 32'(waddr0), 32'd1);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 3) gap(0, 1);
      send(0, 8'($urandom), 1'b0);
    end
    gap(0, 3);
    check("d0 writes drained 2", 32'(q0.size()), 32'd0);

    // Reset mid-frame at byte 500, asserted between clock edges.
    for (int i = 0; i < 500; i++) send(0, 8'($urandom), i == 0);
    #3 rst_n = 1'b0;
    #1;
    check_reset(0);
    check_reset(1);
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      in_frame[d] = 1'b0;
      k[d] = 0;
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send(0, 8'($urandom), 1'b0);
    gap(0, 2);
    check("post-reset busy idle", 32'(busy0), 32'd0);
    send(0, 8'h7E, 1'b1);
    check("post-reset first waddr", 32'(waddr0), 32'd0);
    check("post-reset first we", 32'(we0), 32'd1);
    for (int i = 0; i < 20; i++) send(0, 8'($urandom), 1'b0);
    gap(0, 3);
    check("d0 writes drained 3", 32'(q0.size()), 32'd0);
    check("d0 error pulses", 32'(err_seen[0]), 32'(err_exp[0]));
    check("d1 error pulses", 32'(err_seen[1]), 32'(err_exp[1]));
    check("d1 no frame_done", 32'(done_seen[1]), 32'(done_exp[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
